snd_addr_counter: RTL and testbench
===================================

SND_ADDR_COUNTER -- requirements
Module: snd_addr_counter

Interface
REQ-001 SHALL have clk, input, 1, system clock; all state changes on rising edge.
REQ-002 SHALL have porb, input, 1, power-on reset, asynchronous, active-low.
REQ-003 SHALL have wr, input, 1, register write strobe, one clk cycle per byte.
REQ-004 SHALL have rd, input, 1, register read strobe.
REQ-005 SHALL have regsel, input, 3, byte register select: 0/1/2 start hi/mid/lo, 3/4/5 end hi/mid/lo, 6/7 counter mid/lo; counter hi is read at regsel 0 when rd is asserted.
REQ-006 SHALL have din, input, 8, write data.
REQ-007 SHALL have dout, output, 8, read data.
REQ-008 SHALL have sndon, input, 1, sound DMA enable level.
REQ-009 SHALL have sinc, input, 1, one-cycle word-fetch strobe; advances counter.
REQ-010 SHALL have sframe, input, 1, active-low frame-reload request from sound control.
REQ-011 SHALL have snd, output, 21, current DMA word address [21:1].
REQ-012 SHALL have sft, output, 21, active frame end word address [21:1].
REQ-013 SHALL have fstart, output, 1, one-cycle pulse on each counter (re)load while sndon=1.

Function
REQ-014 SHALL hold shadow start and end registers, 21 bits each; hi byte supplies bits [21:16], mid supplies [15:8], lo supplies [7:1]; din[7:6] of hi and din[0] of lo SHALL be ignored.
REQ-015 SHALL update a shadow register on the clk edge where wr=1; the value SHALL be visible to reads on the next cycle.
REQ-016 While sndon=0, SHALL load snd from shadow start and sft from shadow end every cycle; sinc and sframe are ignored.
REQ-017 On the first cycle with sndon=1 after sndon=0, SHALL keep the values loaded in the previous cycle and pulse fstart.
REQ-018 While sndon=1, shadow writes SHALL NOT alter snd or sft until the next reload.
REQ-019 While sndon=1 and sframe=0, SHALL reload snd from shadow start and sft from shadow end each cycle, and pulse fstart on the first such cycle only.
REQ-020 While sndon=1, sframe=1 and sinc=1, SHALL set snd to snd+1 modulo 2^21; 0x1FFFFF wraps to 0x000000.
REQ-021 If sframe=0 and sinc=1 in the same cycle, reload SHALL win and the increment SHALL be dropped.
REQ-022 If wr targets a start/end byte in the cycle a reload occurs, the reload SHALL use the pre-write shadow value.
REQ-023 snd SHALL NOT saturate or stop at sft; end-of-frame detection belongs to the sound control stage.
REQ-024 dout SHALL be registered, valid one cycle after rd=1, and SHALL hold its value otherwise.
REQ-025 Reads at regsel 1..5 SHALL return the shadow byte, with unused bits read as 0.

Reset
REQ-026 porb=0 SHALL asynchronously clear shadow start, shadow end, snd, sft and dout to 0 and set fstart to 0.
REQ-027 The sndon-edge history SHALL reset to "off" so that sndon=1 on the first cycle after reset pulses fstart.
REQ-028 Reset asserted mid-frame SHALL abort all activity immediately; no partial increment SHALL remain.

Configuration
REQ-029 Macro SND_CNT_READBACK_EN: when defined, rd at regsel 0 SHALL return snd[21:16] and rd at regsel 6/7 SHALL return snd[15:8] and {snd[7:1],0}. A read of snd SHALL latch all of snd on the hi read, and the mid/lo reads SHALL return the latched bytes.
REQ-030 Without SND_CNT_READBACK_EN, regsel 6/7 SHALL read 0, regsel 0 SHALL return the shadow start hi byte, and no latch SHALL exist.

Verification
REQ-031 Write start 0x12/0x34/0x57 and end 0x12/0x35/0x00 with sndon=0 -> next cycle snd=0x091A2B and sft=0x091A80.
REQ-032 With sndon rising, apply 3 sinc pulses -> fstart pulses once, then snd=0x091A2E.
REQ-033 Hold sframe=0 for 2 cycles with sinc=1 -> snd returns to start, exactly one fstart pulse occurs, and no increment is applied.
REQ-034 Set start to 0x1FFFFF, then sndon=1 and one sinc -> snd=0x000000.
REQ-035 Write a new start while sndon=1 -> snd/sft unchanged; after an sframe=0 pulse, snd equals the new start.
REQ-036 Assert porb=0 mid-stream -> all outputs 0 within the same cycle; with SND_CNT_READBACK_EN, reading regsel 0/6/7 after 5 sinc returns the latched snd bytes.

Source files
------------

// File: rtl/snd_addr_counter.sv
// Sound DMA word-address counter with shadow start/end registers and frame reload.
// Optional SND_CNT_READBACK_EN adds a readable, latched copy of the live counter.
module snd_addr_counter (
    input  logic        clk,
    input  logic        porb,
    input  logic        wr,
    input  logic        rd,
    input  logic [2:0]  regsel,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        sndon,
    input  logic        sinc,
    input  logic        sframe,
    output logic [20:0] snd,
    output logic [20:0] sft,
    output logic        fstart
);

    logic [20:0] start_sh;
    logic [20:0] end_sh;
    logic        sndon_d;
    logic        reload_d;
    logic        reload;
    logic        sndon_rise;
    logic [7:0]  rd_data;
`ifdef SND_CNT_READBACK_EN
    logic [20:0] snd_latch;
`endif

    assign reload     = sndon & ~sframe;
    assign sndon_rise = sndon & ~sndon_d;

    // Shadow registers: hi -> [20:15], mid -> [14:7], lo -> [6:0] of the word address.
    always_ff @(posedge clk or negedge porb) begin
        if (!porb) begin
            start_sh <= '0;
            end_sh   <= '0;
        end else if (wr) begin
            case (regsel)
                3'd0: start_sh[20:15] <= din[5:0];
                3'd1: start_sh[14:7]  <= din;
                3'd2: start_sh[6:0]   <= din[7:1];
                3'd3: end_sh[20:15]   <= din[5:0];
                3'd4: end_sh[14:7]    <= din;
                3'd5: end_sh[6:0]     <= din[7:1];
                default: ;
            endcase
        end
    end

    // Reload beats increment; fstart fires on the enable edge or the first cycle of a reload run.
    always_ff @(posedge clk or negedge porb) begin
        if (!porb) begin
            snd      <= '0;
            sft      <= '0;
            fstart   <= 1'b0;
            sndon_d  <= 1'b0;
            reload_d <= 1'b0;
        end else begin
            sndon_d  <= sndon;
            reload_d <= reload;
            fstart   <= 1'b0;
            if (!sndon) begin
                snd <= start_sh;
                sft <= end_sh;
            end else if (reload) begin
                snd    <= start_sh;
                sft    <= end_sh;
                fstart <= sndon_rise | ~reload_d;
            end else if (sndon_rise) begin
                fstart <= 1'b1;
            end else if (sinc) begin
                snd <= snd + 21'd1;
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (regsel)
`ifdef SND_CNT_READBACK_EN
            3'd0: rd_data = {2'b00, snd[20:15]};
            3'd6: rd_data = snd_latch[14:7];
            3'd7: rd_data = {snd_latch[6:0], 1'b0};
`else
            3'd0: rd_data = {2'b00, start_sh[20:15]};
`endif
            3'd1: rd_data = start_sh[14:7];
            3'd2: rd_data = {start_sh[6:0], 1'b0};
            3'd3: rd_data = {2'b00, end_sh[20:15]};
            3'd4: rd_data = end_sh[14:7];
            3'd5: rd_data = {end_sh[6:0], 1'b0};
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge porb) begin
        if (!porb) begin
            dout <= 8'h00;
        end else if (rd) begin
            dout <= rd_data;
        end
    end

`ifdef SND_CNT_READBACK_EN
    // Hi-byte read snapshots the whole counter so mid/lo reads are coherent.
    always_ff @(posedge clk or negedge porb) begin
        if (!porb) begin
            snd_latch <= '0;
        end else if (rd && regsel == 3'd0) begin
            snd_latch <= snd;
        end
    end
`endif

endmodule

// File: tb/tb_snd_addr_counter.sv
// Directed self-checking bench for snd_addr_counter (readback checks follow SND_CNT_READBACK_EN).
module tb_snd_addr_counter;

    logic        clk;
    logic        porb;
    logic        wr;
    logic        rd;
    logic [2:0]  regsel;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        sndon;
    logic        sinc;
    logic        sframe;
    logic [20:0] snd;
    logic [20:0] sft;
    logic        fstart;

    int checks;
    int errors;

    snd_addr_counter dut (
        .clk    (clk),
        .porb   (porb),
        .wr     (wr),
        .rd     (rd),
        .regsel (regsel),
        .din    (din),
        .dout   (dout),
        .sndon  (sndon),
        .sinc   (sinc),
        .sframe (sframe),
        .snd    (snd),
        .sft    (sft),
        .fstart (fstart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [2:0] sel, input logic [7:0] data);
        wr = 1'b1; regsel = sel; din = data;
        step();
        wr = 1'b0;
    endtask

    task automatic rd_byte(input logic [2:0] sel);
        rd = 1'b1; regsel = sel;
        step();
        rd = 1'b0;
    endtask

    task automatic test_reset();
        porb = 1'b0;
        repeat (3) step();
        checks++;
        if ({snd, sft, dout, fstart} !== 51'd0) begin
            errors++;
            $display("FAIL reset_state: snd=%h sft=%h dout=%h fstart=%b, required all 0", snd, sft, dout, fstart);
        end
        porb = 1'b1;
        step();
    endtask

    task automatic test_load();
        wr_byte(3'd0, 8'hD2);
        wr_byte(3'd1, 8'h34);
        wr_byte(3'd2, 8'h57);
        wr_byte(3'd3, 8'h12);
        wr_byte(3'd4, 8'h35);
        wr_byte(3'd5, 8'h00);
        step();
        checks++;
        if (snd !== 21'h091A2B) begin
            errors++;
            $display("FAIL load_snd: got %h required 091a2b", snd);
        end
        checks++;
        if (sft !== 21'h091A80) begin
            errors++;
            $display("FAIL load_sft: got %h required 091a80", sft);
        end
        checks++;
        if (fstart !== 1'b0) begin
            errors++;
            $display("FAIL idle_fstart: got %b required 0", fstart);
        end
        rd_byte(3'd1);
        checks++;
        if (dout !== 8'h34) begin
            errors++;
            $display("FAIL read_start_mid: got %h required 34", dout);
        end
        rd_byte(3'd2);
        checks++;
        if (dout !== 8'h56) begin
            errors++;
            $display("FAIL read_start_lo: got %h required 56", dout);
        end
        rd_byte(3'd3);
        checks++;
        if (dout !== 8'h12) begin
            errors++;
            $display("FAIL read_end_hi: got %h required 12", dout);
        end
        regsel = 3'd5;
        step();
        checks++;
        if (dout !== 8'h12) begin
            errors++;
            $display("FAIL dout_hold: got %h required 12", dout);
        end
        rd_byte(3'd0);
        checks++;
        if (dout !== 8'h12) begin
            errors++;
            $display("FAIL read_reg0: got %h required 12", dout);
        end
    endtask

    task automatic test_sinc();
        int pulses;
        pulses = 0;
        sndon = 1'b1;
        step();
        checks++;
        if (fstart !== 1'b1 || snd !== 21'h091A2B) begin
            errors++;
            $display("FAIL sndon_rise: fstart=%b snd=%h required 1 091a2b", fstart, snd);
        end
        sinc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (fstart === 1'b1) pulses++;
        end
        sinc = 1'b0;
        step();
        checks++;
        if (snd !== 21'h091A2E || pulses !== 0) begin
            errors++;
            $display("FAIL sinc_count: snd=%h extra_pulses=%0d required 091a2e 0", snd, pulses);
        end
    endtask

    task automatic test_reload();
        int pulses;
        pulses = 0;
        sframe = 1'b0; sinc = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            if (fstart === 1'b1) pulses++;
        end
        sframe = 1'b1; sinc = 1'b0;
        step();
        if (fstart === 1'b1) pulses++;
        checks++;
        if (snd !== 21'h091A2B || pulses !== 1) begin
            errors++;
            $display("FAIL reload_over_sinc: snd=%h pulses=%0d required 091a2b 1", snd, pulses);
        end
    endtask

    task automatic test_write_active();
        wr_byte(3'd0, 8'h00);
        wr_byte(3'd1, 8'h10);
        wr_byte(3'd2, 8'h20);
        step();
        checks++;
        if (snd !== 21'h091A2B || sft !== 21'h091A80) begin
            errors++;
            $display("FAIL shadow_isolated: snd=%h sft=%h required 091a2b 091a80", snd, sft);
        end
        sframe = 1'b0;
        step();
        sframe = 1'b1;
        checks++;
        if (snd !== 21'h000810 || sft !== 21'h091A80) begin
            errors++;
            $display("FAIL reload_new_start: snd=%h sft=%h required 000810 091a80", snd, sft);
        end
        sframe = 1'b0;
        wr_byte(3'd2, 8'h40);
        checks++;
        if (snd !== 21'h000810) begin
            errors++;
            $display("FAIL reload_prewrite: snd=%h required 000810", snd);
        end
        step();
        sframe = 1'b1;
        checks++;
        if (snd !== 21'h000820) begin
            errors++;
            $display("FAIL reload_postwrite: snd=%h required 000820", snd);
        end
    endtask

    task automatic test_wrap();
        sndon = 1'b0;
        wr_byte(3'd0, 8'h3F);
        wr_byte(3'd1, 8'hFF);
        wr_byte(3'd2, 8'hFE);
        step();
        sndon = 1'b1;
        step();
        checks++;
        if (snd !== 21'h1FFFFF) begin
            errors++;
            $display("FAIL wrap_preload: snd=%h required 1fffff", snd);
        end
        sinc = 1'b1;
        step();
        sinc = 1'b0;
        checks++;
        if (snd !== 21'h000000) begin
            errors++;
            $display("FAIL wrap_zero: snd=%h required 000000", snd);
        end
    endtask

    task automatic test_readback();
        wr_byte(3'd0, 8'h12);
        wr_byte(3'd1, 8'h34);
        wr_byte(3'd2, 8'h56);
        sframe = 1'b0;
        step();
        sframe = 1'b1;
        sinc = 1'b1;
        repeat (5) step();
        sinc = 1'b0;
        checks++;
        if (snd !== 21'h091A30) begin
            errors++;
            $display("FAIL pre_read_snd: snd=%h required 091a30", snd);
        end
`ifdef SND_CNT_READBACK_EN
        rd_byte(3'd0);
        checks++;
        if (dout !== 8'h12) begin
            errors++;
            $display("FAIL readback_hi: got %h required 12", dout);
        end
        sinc = 1'b1;
        repeat (3) step();
        sinc = 1'b0;
        rd_byte(3'd6);
        checks++;
        if (dout !== 8'h34) begin
            errors++;
            $display("FAIL readback_mid: got %h required 34", dout);
        end
        rd_byte(3'd7);
        checks++;
        if (dout !== 8'h60) begin
            errors++;
            $display("FAIL readback_lo: got %h required 60", dout);
        end
`else
        rd_byte(3'd6);
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL read_reg6: got %h required 00", dout);
        end
        rd_byte(3'd7);
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL read_reg7: got %h required 00", dout);
        end
        rd_byte(3'd0);
        checks++;
        if (dout !== 8'h12) begin
            errors++;
            $display("FAIL read_reg0_start: got %h required 12", dout);
        end
`endif
    endtask

    task automatic test_reset_mid();
        sinc = 1'b1;
        step();
        porb = 1'b0;
        #1;
        checks++;
        if ({snd, sft, dout, fstart} !== 51'd0) begin
            errors++;
            $display("FAIL async_reset: snd=%h sft=%h dout=%h fstart=%b required all 0", snd, sft, dout, fstart);
        end
        sinc = 1'b0;
        step();
        porb = 1'b1;
        step();
        checks++;
        if (fstart !== 1'b1 || snd !== 21'h0) begin
            errors++;
            $display("FAIL post_reset_rise: fstart=%b snd=%h required 1 000000", fstart, snd);
        end
        sndon = 1'b0;
        step();
        checks++;
        if (snd !== 21'h0 || sft !== 21'h0) begin
            errors++;
            $display("FAIL shadow_cleared: snd=%h sft=%h required 0 0", snd, sft);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        porb = 1'b0; wr = 1'b0; rd = 1'b0; regsel = 3'd0; din = 8'h00;
        sndon = 1'b0; sinc = 1'b0; sframe = 1'b1;
        test_reset();
        test_load();
        test_sinc();
        test_reload();
        test_write_active();
        test_wrap();
        test_readback();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
